// File: rtl/dcache_ctrl_if.sv
// CPU and data_mem signal bundle for the direct-mapped data cache.
// The slave modport is the cache side; the master modport is the CPU/memory environment.
interface dcache_ctrl_if;
  logic        RE;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        STALL;
  logic [31:0] CacheRA;
  logic [31:0] CacheRD [16];
  logic        MemWE;
  logic [31:0] MemWA;
  logic [31:0] MemWD;

  modport slave (
    input  RE, WE, A, WD, CacheRD,
    output RD, STALL, CacheRA, MemWE, MemWA, MemWD
  );

  modport master (
    output RE, WE, A, WD, CacheRD,
    input  RD, STALL, CacheRA, MemWE, MemWA, MemWD
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// A load miss stalls, holds the line address for MISS_LAT cycles, then installs the 16-word line.
module dcache_ctrl #(
  parameter int NUM_LINES = 8,
  parameter int MISS_LAT  = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  dcache_ctrl_if.slave    bus,
  output logic [15:0]     HitCnt,
  output logic [15:0]     MissCnt
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 26 - IDX_W;
  localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [25:0]            miss_line_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][16];
  logic [15:0]            hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]       idx_s, fill_idx_s;
  logic [TAG_W-1:0]       tag_s, fill_tag_s;
  logic [3:0]             off_s;
  logic                   match_s;
  logic                   ld_hit_s, ld_miss_s, st_hit_s, fill_done_s;
  logic                   unused_ok_s;

  assign idx_s       = bus.A[6+IDX_W-1:6];
  assign tag_s       = bus.A[31:6+IDX_W];
  assign off_s       = bus.A[5:2];
  assign fill_idx_s  = miss_line_q[IDX_W-1:0];
  assign fill_tag_s  = miss_line_q[25:IDX_W];
  assign match_s     = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign unused_ok_s = ^bus.A[1:0];
  assign HitCnt      = hit_cnt_q;
  assign MissCnt     = miss_cnt_q;

  // Next state, bus outputs and per-cycle actions; everything is forced quiet while in reset.
  always_comb begin
    state_d     = state_q;
    bus.RD      = 32'h0000_0000;
    bus.STALL   = 1'b0;
    bus.CacheRA = 32'h0000_0000;
    bus.MemWE   = 1'b0;
    bus.MemWA   = 32'h0000_0000;
    bus.MemWD   = 32'h0000_0000;
    ld_hit_s    = 1'b0;
    ld_miss_s   = 1'b0;
    st_hit_s    = 1'b0;
    fill_done_s = 1'b0;
    if (RESET_N) begin
      case (state_q)
        S_IDLE: begin
          bus.CacheRA = {bus.A[31:6], 6'b00_0000};
          if (bus.WE) begin
            // A store wins over a simultaneous load request.
            bus.MemWE = 1'b1;
            bus.MemWA = bus.A;
            bus.MemWD = bus.WD;
            st_hit_s  = match_s;
          end else if (bus.RE) begin
            if (match_s) begin
              bus.RD   = data_q[idx_s][off_s];
              ld_hit_s = 1'b1;
            end else begin
              bus.STALL = 1'b1;
              ld_miss_s = 1'b1;
              state_d   = S_FILL;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FILL: begin
          bus.STALL   = 1'b1;
          bus.CacheRA = {miss_line_q, 6'b00_0000};
          if (cnt_q == CNT_W'(MISS_LAT - 1)) begin
            fill_done_s = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // Control state, valid bits and saturating event counters.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      miss_line_q <= 26'd0;
      valid_q     <= '0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (ld_miss_s) begin
        miss_line_q <= bus.A[31:6];
        cnt_q       <= '0;
      end else if (state_q == S_FILL) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (ld_miss_s && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
      if (ld_hit_s && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (fill_done_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset: valid_q gates every use.
  always_ff @(posedge CLK) begin
    if (fill_done_s) begin
      tag_q[fill_idx_s] <= fill_tag_s;
      for (int w = 0; w < 16; w++) begin
        data_q[fill_idx_s][w] <= bus.CacheRD[w];
      end
    end else if (st_hit_s) begin
      data_q[idx_s][off_s] <= bus.WD;
    end
  end
endmodule
